// File: rtl/filter_line_sequencer.sv
// Line sequencer between a pixel stream and a three-row line filter.
// Optional border sweep enabled by defining SEQ_BORDER_EN.
module filter_line_sequencer #(
    parameter int BLOCK_LENGTH = 720,
    parameter int READ_LAT     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    output logic        s_ready,
    output logic [15:0] f_din,
    output logic        f_wren,
    output logic [9:0]  f_cursor,
    input  logic [15:0] f_dout,
    output logic        m_valid,
    output logic [15:0] m_data,
    input  logic        m_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        OUT,
        NEXT
    } state_t;

    localparam logic [9:0] WR_LAST  = 10'(BLOCK_LENGTH - 1);
    localparam logic [2:0] LAT_LAST = 3'(READ_LAT);
`ifdef SEQ_BORDER_EN
    localparam logic [9:0] RD_FIRST = 10'd0;
    localparam logic [9:0] RD_LAST  = 10'(BLOCK_LENGTH - 1);
`else
    localparam logic [9:0] RD_FIRST = 10'd1;
    localparam logic [9:0] RD_LAST  = 10'(BLOCK_LENGTH - 2);
`endif

    state_t      state_q, state_d;
    logic [9:0]  wr_idx_q, wr_idx_d;
    logic [9:0]  rd_idx_q, rd_idx_d;
    logic [2:0]  lat_q, lat_d;
    logic [1:0]  line_cnt_q, line_cnt_d;
    logic [15:0] m_data_q, m_data_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_idx_q   <= 10'd0;
            rd_idx_q   <= 10'd0;
            lat_q      <= 3'd0;
            line_cnt_q <= 2'd0;
            m_data_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            lat_q      <= lat_d;
            line_cnt_q <= line_cnt_d;
            m_data_q   <= m_data_d;
        end
    end

    // Next-state and index/counter updates
    always_comb begin
        logic [1:0] line_base;
        logic [1:0] line_inc;
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        lat_d      = lat_q;
        line_cnt_d = line_cnt_q;
        m_data_d   = m_data_q;
        line_base  = line_cnt_q;
        line_inc   = line_cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d  = WRITE;
                wr_idx_d = 10'd0;
            end
            WRITE: begin
                if (s_valid) begin
                    // SOF only matters on the first pixel of a line
                    if (wr_idx_q == 10'd0 && s_sof) begin
                        line_base = 2'd0;
                    end
                    line_cnt_d = line_base;
                    wr_idx_d   = wr_idx_q + 10'd1;
                    if (wr_idx_q == WR_LAST) begin
                        line_inc   = (line_base == 2'd3) ? 2'd3
                                                         : line_base + 2'd1;
                        line_cnt_d = line_inc;
                        wr_idx_d   = 10'd0;
                        if (line_inc == 2'd3) begin
                            state_d  = READ_WAIT;
                            rd_idx_d = RD_FIRST;
                            lat_d    = 3'd0;
                        end
                    end
                end
            end
            READ_WAIT: begin
`ifdef SEQ_BORDER_EN
                if (rd_idx_q == 10'd0 || rd_idx_q == WR_LAST) begin
                    m_data_d = 16'h0000;
                    lat_d    = 3'd0;
                    state_d  = OUT;
                end else
`endif
                if (lat_q == LAT_LAST) begin
                    m_data_d = f_dout;
                    lat_d    = 3'd0;
                    state_d  = OUT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    if (rd_idx_q == RD_LAST) begin
                        state_d = NEXT;
                    end else begin
                        rd_idx_d = rd_idx_q + 10'd1;
                        lat_d    = 3'd0;
                        state_d  = READ_WAIT;
                    end
                end
            end
            NEXT: begin
                state_d  = WRITE;
                wr_idx_d = 10'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port outputs decoded from the current state
    always_comb begin
        s_ready  = (state_q == WRITE);
        f_wren   = (state_q == WRITE) && s_valid;
        f_din    = f_wren ? s_data : 16'h0000;
        m_valid  = (state_q == OUT);
        m_data   = m_data_q;
        busy     = (state_q != IDLE);
        f_cursor = 10'd0;
        unique case (state_q)
            WRITE:     f_cursor = wr_idx_q;
            READ_WAIT: f_cursor = rd_idx_q;
            OUT:       f_cursor = rd_idx_q;
            default:   f_cursor = 10'd0;
        endcase
    end

endmodule

// File: tb/tb_filter_line_sequencer.sv
// Directed bench for filter_line_sequencer with a delay-line filter model.
// Expectations follow SEQ_BORDER_EN when it is defined for the build.
module tb_filter_line_sequencer;

    localparam int BL = 8;
    localparam int RL = 3;
`ifdef SEQ_BORDER_EN
    localparam int RF = 0;
    localparam int RLAST = BL - 1;
    localparam int BORDER = 1;
`else
    localparam int RF = 1;
    localparam int RLAST = BL - 2;
    localparam int BORDER = 0;
`endif
    localparam int NLINE = RLAST - RF + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_ready;
    logic [15:0] f_din;
    logic        f_wren;
    logic [9:0]  f_cursor;
    logic [15:0] f_dout;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int n_wren = 0;
    int n_xfer = 0;
    int widx = 0;
    logic [15:0] exp_q[$];
    logic [9:0] d1 = '0, d2 = '0, d3 = '0;

    filter_line_sequencer #(.BLOCK_LENGTH(BL), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
        .s_ready(s_ready),
        .f_din(f_din), .f_wren(f_wren), .f_cursor(f_cursor),
        .f_dout(f_dout),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Filter model: output reflects the cursor RL cycles earlier
    always @(posedge clk) begin
        d1 <= f_cursor;
        d2 <= d1;
        d3 <= d2;
    end
    assign f_dout = 16'h5400 | {6'd0, d3};

    function automatic logic [15:0] exp_px(input int i);
        if (BORDER != 0 && (i == 0 || i == BL - 1)) return 16'h0000;
        return 16'h5400 | 16'(i);
    endfunction

    task automatic push_line();
        for (int i = RF; i <= RLAST; i++) exp_q.push_back(exp_px(i));
    endtask

    // Output scoreboard and idle write-port check
    always @(negedge clk) begin
        if (!reset) begin
            if (f_wren) begin
                n_wren++;
            end else begin
                tests++;
                assert (f_din === 16'h0000) else begin
                    fails++;
                    $error("FAIL din_idle observed=%h expected=0000", f_din);
                end
            end
            if (m_valid && m_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL extra_out observed=%h expected=none", m_data);
                end
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    n_out++;
                    tests++;
                    assert (m_data === e) else begin
                        fails++;
                        $error("FAIL m_data observed=%h expected=%h", m_data, e);
                    end
                end
            end
        end
    end

    task automatic send_pix(input logic [15:0] d, input logic sof);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_sof = sof;
        @(negedge clk);
        while (!s_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        tests++;
        assert (s_ready === 1'b1 && f_wren === 1'b1 && f_din === d &&
                f_cursor === 10'(widx)) else begin
            fails++;
            $error("FAIL write observed=%b/%b/%h/%0d expected=1/1/%h/%0d",
                   s_ready, f_wren, f_din, f_cursor, d, widx);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof = 1'b0;
        s_data = 16'h0000;
        widx = (widx + 1) % BL;
        n_xfer++;
    endtask

    task automatic send_line(input logic [15:0] base, input logic sof,
                             input logic toggle);
        for (int i = 0; i < BL; i++) begin
            send_pix(base + 16'(i), sof && (i == 0));
            if (toggle) begin
                @(negedge clk);
                tests++;
                assert (f_wren === 1'b0 && f_din === 16'h0000) else begin
                    fails++;
                    $error("FAIL gap_wren observed=%b/%h expected=0/0000",
                           f_wren, f_din);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL drain observed=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic check_nout(input int e);
        tests++;
        assert (n_out == e) else begin
            fails++;
            $error("FAIL n_out observed=%0d expected=%0d", n_out, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [15:0] hold_d;
        reset = 1'b1;
        s_valid = 1'b0;
        s_data = 16'h0000;
        s_sof = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        assert ({s_ready, f_wren, f_din, f_cursor, m_valid, m_data, busy} ===
                '0) else begin
            fails++;
            $error("FAIL reset observed=%b%b %h %0d %b %h %b expected=zeros",
                   s_ready, f_wren, f_din, f_cursor, m_valid, m_data, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three priming lines, stall on the first output
        send_line(16'h0100, 1'b0, 1'b0);
        send_line(16'h0200, 1'b0, 1'b0);
        push_line();
        m_ready = 1'b0;
        send_line(16'h0300, 1'b0, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!m_valid && cnt < 20);
        tests++;
        assert (cnt == (BORDER != 0 ? 2 : RL + 2)) else begin
            fails++;
            $error("FAIL first_lat observed=%0d expected=%0d",
                   cnt, (BORDER != 0 ? 2 : RL + 2));
        end
        tests++;
        assert (m_valid === 1'b1 && m_data === exp_px(RF) &&
                f_cursor === 10'(RF)) else begin
            fails++;
            $error("FAIL first_out observed=%b/%h/%0d expected=1/%h/%0d",
                   m_valid, m_data, f_cursor, exp_px(RF), RF);
        end
        hold_d = m_data;
        repeat (10) begin
            @(negedge clk);
            tests++;
            assert (m_valid === 1'b1 && m_data === hold_d &&
                    s_ready === 1'b0 && f_wren === 1'b0) else begin
                fails++;
                $error("FAIL stall observed=%b/%h/%b/%b expected=1/%h/0/0",
                       m_valid, m_data, s_ready, f_wren, hold_d);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();
        check_nout(NLINE);
        tests++;
        assert (n_wren == 24 && n_xfer == 24) else begin
            fails++;
            $error("FAIL wren_cnt observed=%0d expected=24", n_wren);
        end

        // SOF on line 4 restarts priming; line 5 has gapped input
        send_line(16'h0400, 1'b1, 1'b0);
        send_line(16'h0500, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_nout(NLINE);
        tests++;
        assert (s_ready === 1'b1) else begin
            fail_msg: begin
                fails++;
                $error("FAIL prime_ready observed=%b expected=1", s_ready);
            end
        end
        push_line();
        send_line(16'h0600, 1'b0, 1'b0);
        wait_drain();
        check_nout(2 * NLINE);

        // Steady state: every line produces a sweep
        push_line();
        send_line(16'h0700, 1'b0, 1'b0);
        wait_drain();
        check_nout(3 * NLINE);

        // Reset mid-line discards it and forces re-priming
        send_pix(16'h0800, 1'b0);
        send_pix(16'h0801, 1'b0);
        send_pix(16'h0802, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        widx = 0;
        @(negedge clk);
        tests++;
        assert ({s_ready, f_wren, f_din, f_cursor, m_valid, m_data, busy} ===
                '0) else begin
            fails++;
            $error("FAIL mid_reset observed=%b%b %h %0d %b %h %b expected=zeros",
                   s_ready, f_wren, f_din, f_cursor, m_valid, m_data, busy);
        end
        @(posedge clk);
        #1;
        send_line(16'h0900, 1'b0, 1'b0);
        send_line(16'h0A00, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_nout(3 * NLINE);
        push_line();
        send_line(16'h0B00, 1'b0, 1'b0);
        wait_drain();
        check_nout(4 * NLINE);
        tests++;
        assert (n_wren == n_xfer) else begin
            fails++;
            $error("FAIL wren_total observed=%0d expected=%0d", n_wren, n_xfer);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_line_sequencer.md
FILTER_LINE_SEQUENCER -- requirements
Module: filter_line_sequencer

Interface
REQ-001 Parameter BLOCK_LENGTH, default 720: pixels per line; legal range 4..1023.
REQ-002 Parameter READ_LAT, default 3: filter cycles from cursor change to valid filter output; legal range 1..7.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 s_valid  input  1  upstream pixel valid.
REQ-006 s_data  input  16  upstream pixel.
REQ-007 s_sof  input  1  start of frame, qualified with the first pixel of a line.
REQ-008 s_ready  output  1  sequencer accepts a pixel this cycle.
REQ-009 f_din  output  16  pixel to filter d_in.
REQ-010 f_wren  output  1  filter row write strobe.
REQ-011 f_cursor  output  10  filter cursor.
REQ-012 f_dout  input  16  filtered pixel from filter d_out.
REQ-013 m_valid  output  1  filtered pixel valid.
REQ-014 m_data  output  16  filtered pixel.
REQ-015 m_ready  input  1  downstream accepts.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, WRITE, READ_WAIT, OUT and NEXT.
REQ-018 IDLE SHALL go to WRITE on the next clk with wr_idx=0.
REQ-019 In WRITE, s_ready SHALL be 1, and a transfer occurs when s_valid&&s_ready.
REQ-020 On each WRITE transfer, f_wren SHALL be 1 for exactly that cycle, with f_din=s_data and f_cursor=wr_idx; wr_idx then increments.
REQ-021 f_wren SHALL be 0 in every cycle without a WRITE transfer.
REQ-022 A transfer with wr_idx=0 and s_sof=1 SHALL clear line_cnt before that line is counted; s_sof at wr_idx!=0 SHALL be ignored.
REQ-023 On the transfer with wr_idx=BLOCK_LENGTH-1, line_cnt SHALL saturate-increment (max 3).
REQ-024 After that transfer, the FSM SHALL go to READ_WAIT if the new line_cnt>=3, else to WRITE with wr_idx=0 (priming).
REQ-025 Outside WRITE, s_ready SHALL be 0.
REQ-026 In READ_WAIT, f_cursor SHALL equal rd_idx and a latency counter SHALL count READ_LAT cycles; on the final count, f_dout SHALL be registered into m_data and the FSM SHALL go to OUT.
REQ-027 rd_idx SHALL start at 1; with SEQ_BORDER_EN it SHALL start at 0 (see REQ-035).
REQ-028 In OUT, m_valid SHALL be 1 and m_data SHALL stay stable until m_valid&&m_ready; m_ready low SHALL stall indefinitely with no other state change.
REQ-029 On an OUT handshake, if rd_idx is the last read index, the FSM SHALL go to NEXT; otherwise rd_idx increments and the FSM returns to READ_WAIT, restarting the latency count.
REQ-030 The last read index SHALL be BLOCK_LENGTH-2 without SEQ_BORDER_EN and BLOCK_LENGTH-1 with it.
REQ-031 NEXT SHALL last one cycle and then go to WRITE with wr_idx=0.
REQ-032 f_cursor SHALL be 0 in IDLE and NEXT; f_din SHALL be 0 when f_wren=0.
REQ-033 Filtered output latency SHALL be READ_LAT+1 cycles from READ_WAIT entry to m_valid.

Reset
REQ-034 While reset=1 at a clk edge, the block SHALL enter IDLE and clear all of: line_cnt, wr_idx, rd_idx, the latency counter, s_ready, f_din, f_wren, f_cursor, m_valid, m_data and busy. Reset in any state, including mid-line or mid-OUT, SHALL discard the partial line and pending output, and the next line SHALL count as priming.

Configuration
REQ-035 Macro SEQ_BORDER_EN:
- Defined: the sweep SHALL cover 0..BLOCK_LENGTH-1, giving BLOCK_LENGTH outputs per line. For rd_idx 0 and BLOCK_LENGTH-1, m_data SHALL be 16'h0000, the latency wait SHALL be skipped (OUT entered the next cycle) and f_dout SHALL be ignored.
- Undefined: the sweep SHALL cover 1..BLOCK_LENGTH-2, giving BLOCK_LENGTH-2 outputs per line, and no border logic SHALL exist.

Verification
REQ-036 Bench config: BLOCK_LENGTH=8, READ_LAT=3, macro undefined, m_ready=1. Stream lines 1–3 -> 24 f_wren pulses; first m_valid exactly 5 cycles after the 24th transfer; 6 outputs with f_cursor 1..6.
REQ-037 Hold m_ready=0 for 10 cycles during the first OUT -> m_valid and m_data stable, s_ready=0 and f_wren=0 throughout; resumes on m_ready=1.
REQ-038 Assert s_sof on the first pixel of line 4 -> no output after line 4; output resumes after line 6.
REQ-039 Assert reset for 1 cycle mid-line 5 -> all outputs 0, state IDLE; 3 complete lines are needed before the next m_valid.
REQ-040 Macro defined, BLOCK_LENGTH=8 -> 8 outputs per line; outputs 1 and 8 are 16'h0000, each appearing 1 cycle after READ_WAIT entry.
REQ-041 s_valid toggled 1/0 each cycle -> f_wren is high only on accepted cycles; f_cursor steps 0..7 with no skips.
